// File: rtl/store_narrow_buffer.sv
// store_narrow_buffer: narrows byte/half/word stores into word-aligned, lane-replicated writes
// queued in a small FIFO; misaligned stores are consumed and flagged instead of queued.
module store_narrow_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_size,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        misalign,
  output logic [31:0] misalign_addr,
  output logic        empty
);
  logic [29:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [3:0]       be_q   [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             mis_q, mis_d;
  logic [31:0]      mis_addr_q, mis_addr_d;
  logic             acc, bad, push, pop;
  logic [31:0]      nwdata;
  logic [3:0]       nbe;
  assign st_ready      = (cnt_q != (PTR_W+1)'(DEPTH)) && !rst;
  assign mem_valid     = cnt_q != '0;
  assign empty         = cnt_q == '0;
  assign mem_addr      = {addr_q[rd_q], 2'b00};
  assign mem_wdata     = data_q[rd_q];
  assign mem_be        = be_q[rd_q];
  assign misalign      = mis_q;
  assign misalign_addr = mis_addr_q;
  always_comb begin
    bad        = st_size == 2'b11 || (st_size == 2'b01 && st_addr[0]) ||
                 (st_size == 2'b10 && st_addr[1:0] != 2'b00);
    acc        = st_valid && st_ready;
    push       = acc && !bad;
    pop        = mem_valid && mem_ready;
    nwdata     = st_size == 2'b00 ? {4{st_data[7:0]}} :
                 st_size == 2'b01 ? {2{st_data[15:0]}} : st_data;
    nbe        = st_size == 2'b00 ? 4'b0001 << st_addr[1:0] :
                 st_size == 2'b01 ? (st_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wr_d       = push ? wr_q + 1'b1 : wr_q;
    rd_d       = pop ? rd_q + 1'b1 : rd_q;
    cnt_d      = cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    mis_d      = acc && bad;
    mis_addr_d = acc && bad ? st_addr : mis_addr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      mis_q      <= 1'b0;
      mis_addr_q <= '0;
    end else begin
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      mis_q      <= mis_d;
      mis_addr_q <= mis_addr_d;
    end
  end
  // Entry storage needs no reset: validity is carried entirely by the count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_q] <= st_addr[31:2];
      data_q[wr_q] <= nwdata;
      be_q[wr_q]   <= nbe;
    end
  end
endmodule
